// File: rtl/simmem_pkg.sv
// Shared widths, slot record type and helpers for the write-response delay tracker.
package simmem_pkg;

  localparam int unsigned WriteRespBankAddrWidth = 3;
  localparam int unsigned DelayWidth = 8;
  localparam int unsigned NumWriteRespSlots = 2 ** WriteRespBankAddrWidth;

  typedef enum logic {
    SLOT_IDLE    = 1'b0,
    SLOT_PENDING = 1'b1
  } slot_state_e;

  typedef struct packed {
    slot_state_e                 pending;
    logic [DelayWidth-1:0]       counter;
  } slot_t;

  // Number of set bits in a slot-wide vector; result spans 0..NumWriteRespSlots.
  function automatic logic [WriteRespBankAddrWidth:0] count_ones(
    input logic [NumWriteRespSlots-1:0] vec
  );
    logic [WriteRespBankAddrWidth:0] cnt;
    cnt = '0;
    for (int i = 0; i < int'(NumWriteRespSlots); i++) begin
      cnt = cnt + {{WriteRespBankAddrWidth{1'b0}}, vec[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/simmem_prio_picker.sv
// Picks the lowest-indexed asserted request out of the slot-wide request vector.
module simmem_prio_picker
  import simmem_pkg::*;
(
  input  logic [NumWriteRespSlots-1:0]      i_req,
  output logic [WriteRespBankAddrWidth-1:0] o_idx,
  output logic                              o_valid
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = int'(NumWriteRespSlots) - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx   = WriteRespBankAddrWidth'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/simmem_delay_tracker.sv
// Per-identifier delay tracker: each slot counts down its delay and is then
// offered for release, lowest identifier first, one per handshake.
module simmem_delay_tracker
  import simmem_pkg::*;
(
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [WriteRespBankAddrWidth-1:0] local_id_i,
  input  logic [DelayWidth-1:0]             delay_i,
  input  logic                              in_valid_i,
  output logic [WriteRespBankAddrWidth-1:0] release_id_o,
  output logic                              release_valid_o,
  input  logic                              release_ready_i,
  output logic                              collision_o,
  output logic [WriteRespBankAddrWidth:0]   pending_cnt_o
);

  slot_t                             r_slots      [NumWriteRespSlots];
  slot_t                             w_slots_next [NumWriteRespSlots];
  logic [NumWriteRespSlots-1:0]      w_expired;
  logic [NumWriteRespSlots-1:0]      w_pending_next;
  logic [WriteRespBankAddrWidth-1:0] w_rel_id;
  logic                              w_rel_valid;
  logic                              w_release;
  logic                              w_collision;
  logic                              r_collision;
  logic [WriteRespBankAddrWidth:0]   r_pending_cnt;

  // A slot is expired once it is pending and its countdown has reached zero.
  always_comb begin
    w_expired = '0;
    for (int i = 0; i < int'(NumWriteRespSlots); i++) begin
      w_expired[i] = (r_slots[i].pending == SLOT_PENDING) && (r_slots[i].counter == '0);
    end
  end

  simmem_prio_picker u_picker (
    .i_req   (w_expired),
    .o_idx   (w_rel_id),
    .o_valid (w_rel_valid)
  );

  assign w_release = w_rel_valid && release_ready_i;

  // Slot next-state: release first, so a same-cycle input to the released slot
  // sees it idle and reloads it; otherwise a pending slot just counts down.
  always_comb begin
    w_pending_next = '0;
    for (int i = 0; i < int'(NumWriteRespSlots); i++) begin
      w_slots_next[i] = r_slots[i];
      if (w_release && (w_rel_id == WriteRespBankAddrWidth'(i))) begin
        w_slots_next[i].pending = SLOT_IDLE;
        w_slots_next[i].counter = '0;
      end else if ((r_slots[i].pending == SLOT_PENDING) && (r_slots[i].counter != '0)) begin
        w_slots_next[i].counter = r_slots[i].counter - DelayWidth'(1);
      end
      if (in_valid_i && (local_id_i == WriteRespBankAddrWidth'(i)) &&
          (w_slots_next[i].pending == SLOT_IDLE)) begin
        w_slots_next[i].pending = SLOT_PENDING;
        w_slots_next[i].counter = delay_i;
      end
      w_pending_next[i] = (w_slots_next[i].pending == SLOT_PENDING);
    end
  end

  // An input hitting a slot that stays pending through this edge is dropped.
  always_comb begin
    w_collision = in_valid_i &&
                  (r_slots[local_id_i].pending == SLOT_PENDING) &&
                  !(w_release && (w_rel_id == local_id_i));
  end

  // Slot state register; reset discards every pending entry immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NumWriteRespSlots); i++) begin
        r_slots[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NumWriteRespSlots); i++) begin
        r_slots[i] <= w_slots_next[i];
      end
    end
  end

  // Collision pulse and pending population, both registered alongside the slots.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_collision   <= 1'b0;
      r_pending_cnt <= '0;
    end else begin
      r_collision   <= w_collision;
      r_pending_cnt <= count_ones(w_pending_next);
    end
  end

  assign release_id_o    = w_rel_id;
  assign release_valid_o = w_rel_valid;
  assign collision_o     = r_collision;
  assign pending_cnt_o   = r_pending_cnt;

endmodule

// File: tb/tb_simmem_delay_tracker.sv
// Bench for simmem_delay_tracker: directed scenarios plus random traffic,
// compared against an absolute-expiry-time reference model.
module tb_simmem_delay_tracker;
  import simmem_pkg::*;

  localparam int NS = NumWriteRespSlots;
  localparam int AW = WriteRespBankAddrWidth;
  localparam int DW = DelayWidth;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic [AW-1:0] local_id_i = '0;
  logic [DW-1:0] delay_i = '0;
  logic          in_valid_i = 1'b0;
  logic [AW-1:0] release_id_o;
  logic          release_valid_o;
  logic          release_ready_i = 1'b0;
  logic          collision_o;
  logic [AW:0]   pending_cnt_o;

  int assertCount = 0;
  int failCount = 0;

  // Reference model: a pending flag and the absolute cycle at which each id
  // becomes releasable.
  bit modelPend [NS];
  int modelExpireAt [NS];
  int modelCycle;
  bit modelColl;
  bit inReset;

  always #5 clk_i = ~clk_i;

  simmem_delay_tracker dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .local_id_i      (local_id_i),
    .delay_i         (delay_i),
    .in_valid_i      (in_valid_i),
    .release_id_o    (release_id_o),
    .release_valid_o (release_valid_o),
    .release_ready_i (release_ready_i),
    .collision_o     (collision_o),
    .pending_cnt_o   (pending_cnt_o)
  );

  function automatic void modelClear();
    for (int i = 0; i < NS; i++) begin
      modelPend[i] = 1'b0;
      modelExpireAt[i] = 0;
    end
    modelCycle = 0;
    modelColl = 1'b0;
  endfunction

  function automatic void modelPick(output bit valid, output int id);
    valid = 1'b0;
    id = 0;
    for (int i = NS - 1; i >= 0; i--) begin
      if (modelPend[i] && (modelCycle >= modelExpireAt[i])) begin
        valid = 1'b1;
        id = i;
      end
    end
  endfunction

  function automatic void modelStep(input bit v, input int id, input int d, input bit rdy);
    bit relValid;
    int relId;
    bit handshake;
    modelPick(relValid, relId);
    handshake = relValid && rdy;
    modelColl = v && modelPend[id] && !(handshake && (relId == id));
    if (handshake) modelPend[relId] = 1'b0;
    if (v && !modelPend[id]) begin
      modelPend[id] = 1'b1;
      modelExpireAt[id] = modelCycle + 1 + d;
    end
    modelCycle++;
  endfunction

  task automatic checkOutput(input string tag);
    bit expValid;
    int expId;
    int expCnt;
    modelPick(expValid, expId);
    expCnt = 0;
    for (int i = 0; i < NS; i++) if (modelPend[i]) expCnt++;

    assertCount++;
    assert (release_valid_o === expValid) else begin
      failCount++;
      $error("FAIL %s.valid cyc=%0d observed=%0b expected=%0b", tag, modelCycle, release_valid_o, expValid);
    end
    if (expValid || inReset) begin
      assertCount++;
      assert (release_id_o === AW'(expId)) else begin
        failCount++;
        $error("FAIL %s.id cyc=%0d observed=%0d expected=%0d", tag, modelCycle, release_id_o, expId);
      end
    end
    assertCount++;
    assert (collision_o === modelColl) else begin
      failCount++;
      $error("FAIL %s.collision cyc=%0d observed=%0b expected=%0b", tag, modelCycle, collision_o, modelColl);
    end
    assertCount++;
    assert (pending_cnt_o === (AW+1)'(expCnt)) else begin
      failCount++;
      $error("FAIL %s.pending cyc=%0d observed=%0d expected=%0d", tag, modelCycle, pending_cnt_o, expCnt);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, check mid-cycle, then
  // advance the model across the next rising edge.
  task automatic applyStimulus(input bit v, input int id, input int d, input bit rdy, input string tag);
    in_valid_i = v;
    local_id_i = AW'(id);
    delay_i = DW'(d);
    release_ready_i = rdy;
    @(negedge clk_i);
    checkOutput(tag);
    modelStep(v, id, d, rdy);
    @(posedge clk_i);
    #1;
  endtask

  task automatic idleCycles(input int n, input bit rdy, input string tag);
    repeat (n) applyStimulus(1'b0, 0, 0, rdy, tag);
  endtask

  task automatic applyReset(input string tag);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    in_valid_i = 1'b0;
    local_id_i = '0;
    delay_i = '0;
    release_ready_i = 1'b0;
    #2;
    modelClear();
    inReset = 1'b1;
    checkOutput(tag);
    inReset = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    inReset = 1'b0;
    modelClear();
    $display("[TB] starting simmem_delay_tracker bench, %0d slots", NS);

    applyReset("reset");

    // Single entry: id 3, delay 10 in cycle 5, consumer always ready.
    idleCycles(5, 1'b1, "single");
    applyStimulus(1'b1, 3, 10, 1'b1, "single");
    idleCycles(14, 1'b1, "single");

    // Delay zero releases in the very next cycle.
    applyStimulus(1'b1, 0, 0, 1'b1, "delay0");
    idleCycles(3, 1'b1, "delay0");

    // Backpressure: id 5 then id 2 expire while blocked; release switches to 2.
    applyStimulus(1'b1, 5, 4, 1'b0, "backpr");
    applyStimulus(1'b1, 2, 4, 1'b0, "backpr");
    idleCycles(10, 1'b0, "backpr");
    idleCycles(4, 1'b1, "backpr");

    // Collision: a second request to id 1 is dropped and pulses collision.
    applyStimulus(1'b1, 1, 8, 1'b1, "collide");
    applyStimulus(1'b0, 0, 0, 1'b1, "collide");
    applyStimulus(1'b1, 1, 3, 1'b1, "collide");
    idleCycles(12, 1'b1, "collide");

    // Release/reload overlap on id 4.
    applyStimulus(1'b1, 4, 2, 1'b0, "reload");
    idleCycles(2, 1'b0, "reload");
    applyStimulus(1'b1, 4, 3, 1'b1, "reload");
    idleCycles(7, 1'b1, "reload");

    // Random traffic with random backpressure, then drain.
    for (int n = 0; n < 400; n++) begin
      applyStimulus(bit'($urandom_range(0, 1)), int'($urandom_range(0, NS - 1)),
                    int'($urandom_range(0, 15)), ($urandom_range(0, 9) < 7), "random");
    end
    idleCycles(30, 1'b1, "drain");

    // Fill every slot, then reset mid-countdown.
    for (int i = 0; i < NS; i++) applyStimulus(1'b1, i, 60, 1'b1, "fill");
    idleCycles(2, 1'b1, "fill");
    assertCount++;
    assert (pending_cnt_o === (AW+1)'(NS)) else begin
      failCount++;
      $error("FAIL fill.full observed=%0d expected=%0d", pending_cnt_o, NS);
    end
    applyReset("midreset");
    idleCycles(80, 1'b1, "postreset");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/simmem_delay_tracker.md
SIMMEM_DELAY_TRACKER -- requirements
Module: simmem_delay_tracker

Interface
REQ-001 No parameters SHALL exist; all widths SHALL come from simmem_pkg: WriteRespBankAddrWidth (AW), DelayWidth (DW), NumWriteRespSlots = 2**AW (NS).
REQ-002 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 local_id_i  input  AW  local identifier of the write response being scheduled.
REQ-005 delay_i  input  DW  delay in cycles for that identifier.
REQ-006 in_valid_i  input  1  local_id_i/delay_i valid this cycle; no ready, always accepted.
REQ-007 release_id_o  output  AW  identifier whose delay has expired.
REQ-008 release_valid_o  output  1  release_id_o valid.
REQ-009 release_ready_i  input  1  consumer accepts release_id_o.
REQ-010 collision_o  output  1  one-cycle pulse: in_valid_i targeted an already-pending slot.
REQ-011 pending_cnt_o  output  AW+1  number of slots currently pending.

Function
REQ-012 The block SHALL hold NS slots indexed directly by local identifier, each with a pending bit and a DW-bit down-counter.
REQ-013 Each slot SHALL be a two-state machine: IDLE -> PENDING on accepted input; PENDING -> IDLE on release handshake.
REQ-014 On in_valid_i at cycle t for an IDLE slot, the slot SHALL become PENDING with counter = delay_i at the edge ending cycle t.
REQ-015 Each PENDING slot with counter > 0 SHALL decrement by 1 per cycle; counter SHALL never wrap below 0.
REQ-016 A PENDING slot with counter == 0 is expired; accepted at cycle t with delay d, it SHALL be expired from cycle t+1+d (delay 0 -> cycle t+1).
REQ-017 release_valid_o SHALL be high iff at least one slot is expired; release_id_o SHALL be the lowest-indexed expired slot (combinational from state).
REQ-018 release_id_o SHALL be held stable while release_valid_o is high and release_ready_i low, unless a lower-indexed slot expires meanwhile; in that case release_id_o SHALL switch to the lower index.
REQ-019 On release_valid_o && release_ready_i, the selected slot SHALL return to IDLE at that edge.
REQ-020 in_valid_i to a PENDING slot not released in the same cycle SHALL be ignored (slot unchanged) and collision_o SHALL be high in the following cycle only.
REQ-021 in_valid_i to the slot being released in the same cycle SHALL reload it (PENDING, counter = delay_i); no collision.
REQ-022 pending_cnt_o SHALL equal the registered count of PENDING slots, range 0..NS inclusive; all-full SHALL report NS without overflow.
REQ-023 Multiple simultaneous expiries SHALL be released one per handshake cycle in ascending index order.

Reset
REQ-024 While rst_ni is low, all slots SHALL be IDLE with counter 0; release_valid_o = 0, release_id_o = 0, collision_o = 0, pending_cnt_o = 0.
REQ-025 Reset assertion mid-operation SHALL discard all pending slots immediately, with no release after deassertion.
REQ-026 The first input SHALL be accepted in the first cycle after rst_ni deasserts.

Structure
REQ-027 WriteRespBankAddrWidth, DelayWidth and NumWriteRespSlots SHALL live in simmem_pkg; a slot struct type (pending, counter) SHALL be added there.
REQ-028 Lowest-index selection SHALL be a sub-module simmem_prio_picker (NS-bit request vector in; index and valid out).

Verification
REQ-029 Single entry: id 3, delay 10 at cycle 5, release_ready_i = 1 -> release_valid_o high at cycle 16 only, with release_id_o = 3; pending_cnt_o 1 -> 0.
REQ-030 Delay zero: id 0, delay 0 at cycle 2 -> release in cycle 3.
REQ-031 Backpressure: ids 5 and 2, delay 4 in the same-timed sequence, release_ready_i = 0 until cycle 20 -> id 2 released first, then 5, on consecutive cycles.
REQ-032 Collision: id 1, delay 8, then id 1 again at +2 -> collision_o pulse for one cycle; release at the original time, once only.
REQ-033 Release/reload overlap: id 4 expired and handshaking while in_valid_i for id 4 with delay 3 -> no collision; id 4 re-released 4 cycles later.
REQ-034 Fill all NS slots, then reset mid-countdown -> pending_cnt_o = NS before the reset; all outputs 0 after the reset; no releases afterward.
